spsram_bist: RTL
================

SPSRAM_BIST -- requirements
Module: spsram_bist

Interface
REQ-001 Parameter BW_DATA, default 32, SRAM data width.
REQ-002 Parameter BW_ADDR, default 5, SRAM address width; depth = 2^BW_ADDR.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rstn  input  1  synchronous, active-low reset.
REQ-005 i_start  input  1  request one test run; sampled only in IDLE.
REQ-006 i_seed  input  BW_DATA  pattern seed; captured when start is accepted.
REQ-007 i_mem_data  input  BW_DATA  SRAM read data (SRAM o_data).
REQ-008 o_mem_data  output  BW_DATA  SRAM write data.
REQ-009 o_mem_addr  output  BW_ADDR  SRAM address.
REQ-010 o_mem_wen, o_mem_cen, o_mem_oen  output  1 each  SRAM write, chip and output enables, active-high.
REQ-011 o_busy  output  1  test in progress.
REQ-012 o_done  output  1  one-cycle pulse at test end.
REQ-013 o_fail  output  1  sticky mismatch flag.
REQ-014 o_fail_addr  output  BW_ADDR  address of first mismatch.
REQ-015 o_fail_data  output  BW_DATA  read data of first mismatch.

Function
REQ-016 The block SHALL be the initiator side of the single-port SRAM port; all o_mem_* and status outputs SHALL be registered.
REQ-017 States SHALL be IDLE, WR, RD, DRAIN, DONE; cycle 0 is the cycle after the edge that samples i_start=1 in IDLE.
REQ-018 IDLE: o_mem_cen/wen/oen=0, o_mem_addr=0, o_mem_data=0, o_busy=0; i_start=1 -> WR, seed captured, o_fail/o_fail_addr/o_fail_data cleared.
REQ-019 WR: one write per cycle, addr 0..2^BW_ADDR-1 ascending, cen=1, wen=1, oen=0, data = seed + addr, addition modulo 2^BW_DATA (addr zero-extended).
REQ-020 RD: one read per cycle, addr 0..2^BW_ADDR-1 ascending, cen=1, wen=0, oen=1, o_mem_data=0.
REQ-021 SRAM read latency SHALL be one cycle: i_mem_data compared in the cycle after the read is issued, against the expected pattern of the delayed address.
REQ-022 DRAIN: one cycle, cen=wen=oen=0, final read compared.
REQ-023 DONE: one cycle, o_done=1, o_busy=0, then IDLE; o_busy=1 in WR, RD, DRAIN.
REQ-024 Default timing, depth 32: writes cycles 0-31, reads 32-63, DRAIN 64, o_done in cycle 65.
REQ-025 On mismatch: o_fail=1; o_fail_addr/o_fail_data captured on the first mismatch only; later mismatches do not overwrite; the run always completes.
REQ-026 o_fail, o_fail_addr, o_fail_data SHALL hold after DONE until the next accepted start.
REQ-027 i_start while not in IDLE SHALL be ignored; i_seed changes after acceptance have no effect.
REQ-028 Address counter SHALL end the pass at 2^BW_ADDR-1 without wrap-driven extra access.

Reset
REQ-029 i_rstn=0 at an edge SHALL force IDLE and zero every output, including o_fail, o_fail_addr and o_fail_data, regardless of the current state.
REQ-030 Reset mid-run SHALL abort with no o_done pulse; the next start restarts from WR addr 0.

Configuration
REQ-031 Macro SPSRAM_BIST_INV_EN defined: after DRAIN, pass WR_INV writes ~(seed+addr), then RD_INV reads, then DRAIN, compared against ~(seed+addr), then DONE; depth 32 -> o_done in cycle 130.
REQ-032 Macro undefined: no inverted passes; DRAIN goes directly to DONE (REQ-024 timing).

Verification
REQ-033 Reset held 3 cycles, then idle 10 cycles -> all outputs 0, no SRAM access.
REQ-034 Seed 0, fault-free 1-cycle SRAM model -> addr 5 written 0x00000005; o_done in cycle 65; o_fail=0.
REQ-035 Seed 0xFFFFFFFF -> addr 0 written 0xFFFFFFFF, addr 1 written 0x00000000 (wrap); o_fail=0.
REQ-036 Model forces bit 3=1 at addr 7 and bit 0=1 at addr 9, seed 0 -> o_fail=1, o_fail_addr=7, o_fail_data=0x0000000F, held after o_done.
REQ-037 i_start pulsed in cycle 10 -> ignored; i_rstn=0 at cycle 40 -> next cycle all outputs 0, o_busy=0, no o_done.
REQ-038 SPSRAM_BIST_INV_EN, seed 0, addr 0 bit 0 stuck-at-0 -> o_fail=1, o_fail_addr=0, o_fail_data=0xFFFFFFFE, o_done in cycle 130; same fault without macro -> o_fail=0.

Source files
------------

// File: rtl/spsram_bist.sv
// spsram_bist: built-in self test engine for a single-port SRAM.
// The engine writes an incrementing pattern (seed + address) to every location
// and then reads every location back. The SRAM has one cycle of read latency.
// The first mismatch is recorded, and the flags stay set until the next run.
// Optional feature macro: SPSRAM_BIST_INV_EN. When it is defined, a second
// write/read pass follows, using the inverted pattern ~(seed + address).
module spsram_bist #(
   parameter int BW_DATA = 32,
   parameter int BW_ADDR = 5
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_start,
   input  logic [BW_DATA-1:0] i_seed,
   input  logic [BW_DATA-1:0] i_mem_data,
   output logic [BW_DATA-1:0] o_mem_data,
   output logic [BW_ADDR-1:0] o_mem_addr,
   output logic               o_mem_wen,
   output logic               o_mem_cen,
   output logic               o_mem_oen,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_fail,
   output logic [BW_ADDR-1:0] o_fail_addr,
   output logic [BW_DATA-1:0] o_fail_data
);

   // Sequencer states. The inverted-pattern states exist only with the feature.
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WR        = 3'd1;
   localparam logic [2:0] ST_RD        = 3'd2;
   localparam logic [2:0] ST_DRAIN     = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;
`ifdef SPSRAM_BIST_INV_EN
   localparam logic [2:0] ST_WR_INV    = 3'd5;
   localparam logic [2:0] ST_RD_INV    = 3'd6;
   localparam logic [2:0] ST_DRAIN_INV = 3'd7;
`endif

   localparam logic [BW_ADDR-1:0] ADDR_LAST = {BW_ADDR{1'b1}};

   // The expected word for an address. The address is zero-extended, and the
   // sum wraps modulo 2^BW_DATA.
   function automatic logic [BW_DATA-1:0] pattern(
      input logic [BW_DATA-1:0] seed,
      input logic [BW_ADDR-1:0] addr,
      input logic               inv
   );
      logic [BW_DATA-1:0] p;
      p = seed + BW_DATA'(addr);
      return inv ? ~p : p;
   endfunction

   logic [2:0]         state_reg,     state_next;
   logic [BW_DATA-1:0] seed_reg,      seed_next;
   logic [BW_ADDR-1:0] mem_addr_reg,  mem_addr_next;
   logic [BW_DATA-1:0] mem_data_reg,  mem_data_next;
   logic               mem_wen_reg,   mem_wen_next;
   logic               mem_cen_reg,   mem_cen_next;
   logic               mem_oen_reg,   mem_oen_next;
   logic               busy_reg,      busy_next;
   logic               done_reg,      done_next;
   logic               fail_reg,      fail_next;
   logic [BW_ADDR-1:0] fail_addr_reg, fail_addr_next;
   logic [BW_DATA-1:0] fail_data_reg, fail_data_next;

   // Compare pipeline. Each stage holds the read that was issued one cycle
   // earlier, so it lines up with the data that the SRAM returns.
   logic               cmp_valid_reg, cmp_valid_next;
   logic [BW_ADDR-1:0] cmp_addr_reg,  cmp_addr_next;
   logic               cmp_inv_reg,   cmp_inv_next;

   logic [BW_ADDR-1:0] addr_inc;
   logic [BW_DATA-1:0] cmp_expect;
   logic               cmp_mismatch;

   assign addr_inc     = mem_addr_reg + BW_ADDR'(1);
   assign cmp_expect   = pattern(seed_reg, cmp_addr_reg, cmp_inv_reg);
   assign cmp_mismatch = cmp_valid_reg && (i_mem_data != cmp_expect);

   // Next-state logic, SRAM access, and read-back checking.
   // Every output is decided here one cycle early and then registered.
   always_comb begin
      state_next     = state_reg;
      seed_next      = seed_reg;
      mem_addr_next  = '0;
      mem_data_next  = '0;
      mem_wen_next   = 1'b0;
      mem_cen_next   = 1'b0;
      mem_oen_next   = 1'b0;
      busy_next      = 1'b0;
      done_next      = 1'b0;
      fail_next      = fail_reg;
      fail_addr_next = fail_addr_reg;
      fail_data_next = fail_data_reg;

      // Whatever read is on the port now returns data in the next cycle.
      cmp_valid_next = mem_cen_reg & mem_oen_reg;
      cmp_addr_next  = mem_addr_reg;
`ifdef SPSRAM_BIST_INV_EN
      cmp_inv_next   = (state_reg == ST_RD_INV);
`else
      cmp_inv_next   = 1'b0;
`endif

      // The sticky flag is set on every mismatch.
      // The address and data are captured only on the first one.
      if (cmp_mismatch) begin
         fail_next = 1'b1;
         if (!fail_reg) begin
            fail_addr_next = cmp_addr_reg;
            fail_data_next = i_mem_data;
         end
      end

      case (state_reg)
         ST_IDLE: begin
            if (i_start) begin
               state_next     = ST_WR;
               seed_next      = i_seed;
               fail_next      = 1'b0;
               fail_addr_next = '0;
               fail_data_next = '0;
               busy_next      = 1'b1;
               mem_cen_next   = 1'b1;
               mem_wen_next   = 1'b1;
               mem_data_next  = pattern(i_seed, '0, 1'b0);
            end
         end

         ST_WR: begin
            busy_next    = 1'b1;
            mem_cen_next = 1'b1;
            if (mem_addr_reg == ADDR_LAST) begin
               state_next   = ST_RD;
               mem_oen_next = 1'b1;
            end else begin
               mem_wen_next  = 1'b1;
               mem_addr_next = addr_inc;
               mem_data_next = pattern(seed_reg, addr_inc, 1'b0);
            end
         end

         ST_RD: begin
            busy_next = 1'b1;
            if (mem_addr_reg == ADDR_LAST) begin
               state_next = ST_DRAIN;
            end else begin
               mem_cen_next  = 1'b1;
               mem_oen_next  = 1'b1;
               mem_addr_next = addr_inc;
            end
         end

         // The port is quiet for this cycle while the last read is checked.
         ST_DRAIN: begin
`ifdef SPSRAM_BIST_INV_EN
            state_next    = ST_WR_INV;
            busy_next     = 1'b1;
            mem_cen_next  = 1'b1;
            mem_wen_next  = 1'b1;
            mem_data_next = pattern(seed_reg, '0, 1'b1);
`else
            state_next = ST_DONE;
            done_next  = 1'b1;
`endif
         end

`ifdef SPSRAM_BIST_INV_EN
         ST_WR_INV: begin
            busy_next    = 1'b1;
            mem_cen_next = 1'b1;
            if (mem_addr_reg == ADDR_LAST) begin
               state_next   = ST_RD_INV;
               mem_oen_next = 1'b1;
            end else begin
               mem_wen_next  = 1'b1;
               mem_addr_next = addr_inc;
               mem_data_next = pattern(seed_reg, addr_inc, 1'b1);
            end
         end

         ST_RD_INV: begin
            busy_next = 1'b1;
            if (mem_addr_reg == ADDR_LAST) begin
               state_next = ST_DRAIN_INV;
            end else begin
               mem_cen_next  = 1'b1;
               mem_oen_next  = 1'b1;
               mem_addr_next = addr_inc;
            end
         end

         ST_DRAIN_INV: begin
            state_next = ST_DONE;
            done_next  = 1'b1;
         end
`endif

         ST_DONE: begin
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State and output registers, with a synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_reg     <= ST_IDLE;
         seed_reg      <= '0;
         mem_addr_reg  <= '0;
         mem_data_reg  <= '0;
         mem_wen_reg   <= 1'b0;
         mem_cen_reg   <= 1'b0;
         mem_oen_reg   <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         fail_reg      <= 1'b0;
         fail_addr_reg <= '0;
         fail_data_reg <= '0;
         cmp_valid_reg <= 1'b0;
         cmp_addr_reg  <= '0;
         cmp_inv_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         seed_reg      <= seed_next;
         mem_addr_reg  <= mem_addr_next;
         mem_data_reg  <= mem_data_next;
         mem_wen_reg   <= mem_wen_next;
         mem_cen_reg   <= mem_cen_next;
         mem_oen_reg   <= mem_oen_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         fail_reg      <= fail_next;
         fail_addr_reg <= fail_addr_next;
         fail_data_reg <= fail_data_next;
         cmp_valid_reg <= cmp_valid_next;
         cmp_addr_reg  <= cmp_addr_next;
         cmp_inv_reg   <= cmp_inv_next;
      end
   end

   assign o_mem_data  = mem_data_reg;
   assign o_mem_addr  = mem_addr_reg;
   assign o_mem_wen   = mem_wen_reg;
   assign o_mem_cen   = mem_cen_reg;
   assign o_mem_oen   = mem_oen_reg;
   assign o_busy      = busy_reg;
   assign o_done      = done_reg;
   assign o_fail      = fail_reg;
   assign o_fail_addr = fail_addr_reg;
   assign o_fail_data = fail_data_reg;

endmodule
